// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: loads the PISO on accept, shifts it once per data bit, and frames txd.
// The accept edge drives txd low on the next cycle. Requests while busy are dropped. All outputs are registered.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [DATA_BITS-1:0] piso_data,
    output logic                 piso_load,
    output logic                 piso_shift,
    input  logic                 piso_serial,
    output logic                 txd
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [15:0] BAUD_MAX  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        ODD       = (PARITY_ODD != 0);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
        PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1 ||
        STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx_ctrl: parameter out of legal range");
    end

    state_t      state, state_nxt;
    logic [15:0] baud;
    logic [2:0]  bit_cnt;
    logic        parity_bit;
    logic        baud_wrap, accept;
    logic        txd_nxt, load_nxt, shift_nxt, done_nxt;

    assign baud_wrap = (baud == BAUD_MAX);
    assign accept    = (state == IDLE) && tx_start;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            baud       <= '0;
            bit_cnt    <= '0;
            parity_bit <= 1'b0;
            piso_data  <= '0;
            txd        <= 1'b1;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
            piso_load  <= 1'b0;
            piso_shift <= 1'b0;
        end else begin
            state <= state_nxt;
            baud  <= (state == IDLE || baud_wrap) ? '0 : baud + 16'd1;
            if (state_nxt != state)
                bit_cnt <= '0;
            else if (baud_wrap)
                bit_cnt <= bit_cnt + 3'd1;
            if (accept) begin
                piso_data  <= tx_data;
                parity_bit <= (^tx_data) ^ ODD;
            end
            txd        <= txd_nxt;
            tx_busy    <= (state_nxt != IDLE);
            tx_done    <= done_nxt;
            piso_load  <= load_nxt;
            piso_shift <= shift_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (tx_start) state_nxt = START;
            START:  if (baud_wrap) state_nxt = DATA;
            DATA:   if (baud_wrap && bit_cnt == DATA_LAST)
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
            PARITY: if (baud_wrap) state_nxt = STOP;
            STOP:   if (baud_wrap && bit_cnt == STOP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // txd for each bit is registered at its entry edge; PISO is loaded well before START ends.
    always_comb begin
        txd_nxt   = txd;
        load_nxt  = 1'b0;
        shift_nxt = 1'b0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                txd_nxt  = ~tx_start;
                load_nxt = tx_start;
            end
            START: if (baud_wrap) begin
                txd_nxt   = piso_serial;
                shift_nxt = 1'b1;
            end
            DATA: if (baud_wrap) begin
                if (bit_cnt == DATA_LAST) begin
                    txd_nxt = (PARITY_EN != 0) ? parity_bit : 1'b1;
                end else begin
                    txd_nxt   = piso_serial;
                    shift_nxt = 1'b1;
                end
            end
            PARITY: if (baud_wrap) txd_nxt = 1'b1;
            STOP: begin
                txd_nxt  = 1'b1;
                done_nxt = baud_wrap && (bit_cnt == STOP_LAST);
            end
            default: txd_nxt = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Four sequencer configurations (8N1, 8E1, 8O1, 8N2) with behavioural PISOs; a per-instance monitor
// reconstructs each frame from txd and checks it against expected frames queued at stimulus time.
module tb_uart_tx_ctrl;
    localparam int CPB = 4;
    localparam logic [3:0] P_EN  = 4'b0110;
    localparam logic [3:0] P_ODD = 4'b0100;
    localparam logic [3:0] TWO_S = 4'b1000;

    typedef struct packed {
        int          inst;
        logic [11:0] bits;
        int          len;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       tx_start    [4];
    logic [7:0] tx_data     [4];
    logic       tx_busy     [4];
    logic       tx_done     [4];
    logic [7:0] piso_data   [4];
    logic       piso_load   [4];
    logic       piso_shift  [4];
    logic       piso_serial [4];
    logic       txd         [4];

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        logic [7:0] piso_q;

        uart_tx_ctrl #(
            .CLKS_PER_BIT(CPB),
            .DATA_BITS   (8),
            .PARITY_EN   (P_EN[g] ? 1 : 0),
            .PARITY_ODD  (P_ODD[g] ? 1 : 0),
            .STOP_BITS   (TWO_S[g] ? 2 : 1)
        ) u_dut (
            .clk        (clk),
            .reset      (reset),
            .tx_start   (tx_start[g]),
            .tx_data    (tx_data[g]),
            .tx_busy    (tx_busy[g]),
            .tx_done    (tx_done[g]),
            .piso_data  (piso_data[g]),
            .piso_load  (piso_load[g]),
            .piso_shift (piso_shift[g]),
            .piso_serial(piso_serial[g]),
            .txd        (txd[g])
        );

        always @(posedge clk) begin
            if (piso_load[g])       piso_q <= piso_data[g];
            else if (piso_shift[g]) piso_q <= {1'b0, piso_q[7:1]};
        end
        assign piso_serial[g] = piso_q[0];

        initial begin : mon
            int          cyc, shifts, loads, holds, both;
            logic [11:0] bits;
            logic        cur;
            exp_t        e;
            cyc = 0; shifts = 0; loads = 0; holds = 0; both = 0; bits = '0; cur = 1'b1;
            forever begin
                @(negedge clk);
                if (reset) begin
                    cyc = 0; shifts = 0; loads = 0; holds = 0; bits = '0;
                end else begin
                    if (piso_load[g] && piso_shift[g]) both++;
                    if (tx_busy[g]) begin
                        if (cyc % CPB == 0) begin
                            bits = {bits[10:0], txd[g]};
                            cur  = txd[g];
                        end else if (txd[g] != cur) begin
                            holds++;
                        end
                        cyc++;
                        if (piso_shift[g]) shifts++;
                        if (piso_load[g])  loads++;
                    end
                    if (tx_done[g]) begin
                        if (exp_q.size() == 0) begin
                            chk(1'b0, $sformatf("i%0d_unexpected_done", g), 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            chk(e.inst == g, $sformatf("i%0d_frame_owner", g), g, e.inst);
                            chk(bits == e.bits, $sformatf("i%0d_frame_bits", g), int'(bits), int'(e.bits));
                            chk(cyc == e.len * CPB, $sformatf("i%0d_busy_cycles", g), cyc, e.len * CPB);
                            chk(shifts == 8, $sformatf("i%0d_shift_pulses", g), shifts, 8);
                            chk(loads == 1, $sformatf("i%0d_load_pulses", g), loads, 1);
                            chk(holds == 0, $sformatf("i%0d_bit_hold", g), holds, 0);
                            chk(both == 0, $sformatf("i%0d_load_shift_overlap", g), both, 0);
                            chk(!tx_busy[g], $sformatf("i%0d_busy_at_done", g), int'(tx_busy[g]), 0);
                        end
                        cyc = 0; shifts = 0; loads = 0; holds = 0; bits = '0;
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d, input logic [11:0] bits, input int len);
        @(negedge clk);
        tx_start[k] = 1'b1;
        tx_data[k]  = d;
        exp_q.push_back('{k, bits, len});
        @(negedge clk);
        tx_start[k] = 1'b0;
        tx_data[k]  = ~d;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(exp_q.size() == 0, name, exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        repeat (30000) @(posedge clk);
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int n, n_done;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tx_start[k] = 1'b0;
            tx_data[k]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk(txd[k] == 1'b1, $sformatf("i%0d_reset_txd", k), int'(txd[k]), 1);
            chk(tx_busy[k] == 1'b0, $sformatf("i%0d_reset_busy", k), int'(tx_busy[k]), 0);
            chk(tx_done[k] == 1'b0, $sformatf("i%0d_reset_done", k), int'(tx_done[k]), 0);
            chk(!piso_load[k] && !piso_shift[k], $sformatf("i%0d_reset_piso_en", k),
                int'({piso_load[k], piso_shift[k]}), 0);
        end
        reset = 1'b0;

        // 8N1
        send(0, 8'h8F, 12'b00_0_11110001_1, 10);
        drain("i0_8f_drain");
        // even parity, then odd parity
        send(1, 8'h07, 12'b0_0_11100000_1_1, 11);
        drain("i1_07_drain");
        send(1, 8'hC3, 12'b0_0_11000011_0_1, 11);
        drain("i1_c3_drain");
        send(2, 8'h07, 12'b0_0_11100000_0_1, 11);
        drain("i2_07_drain");
        // two stop bits
        send(3, 8'h00, 12'b0_0_00000000_1_1, 11);
        drain("i3_00_drain");
        send(3, 8'hFF, 12'b0_0_11111111_1_1, 11);
        drain("i3_ff_drain");

        // tx_start held: second frame accepted in the tx_done cycle
        @(negedge clk);
        tx_start[0] = 1'b1;
        tx_data[0]  = 8'hA5;
        exp_q.push_back('{0, 12'b00_0_10100101_1, 10});
        exp_q.push_back('{0, 12'b00_0_00111100_1, 10});
        @(negedge clk);
        tx_data[0] = 8'h3C;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tx_done[0] && n < 100);
        chk(tx_done[0] == 1'b1, "b2b_first_done", int'(tx_done[0]), 1);
        @(negedge clk);
        chk(tx_busy[0] == 1'b1, "b2b_busy_no_gap", int'(tx_busy[0]), 1);
        chk(txd[0] == 1'b0, "b2b_start_bit", int'(txd[0]), 0);
        tx_start[0] = 1'b0;
        drain("b2b_drain");

        // reset during data bit 3
        @(negedge clk);
        tx_start[0] = 1'b1;
        tx_data[0]  = 8'h8F;
        @(negedge clk);
        tx_start[0] = 1'b0;
        repeat (17) @(negedge clk);
        chk(tx_busy[0] == 1'b1, "midrst_busy_before", int'(tx_busy[0]), 1);
        reset = 1'b1;
        #1;
        chk(txd[0] == 1'b1, "midrst_txd", int'(txd[0]), 1);
        chk(tx_busy[0] == 1'b0, "midrst_busy", int'(tx_busy[0]), 0);
        chk(!piso_shift[0] && !piso_load[0], "midrst_piso_en",
            int'({piso_load[0], piso_shift[0]}), 0);
        chk(piso_data[0] == 8'h00, "midrst_piso_data", int'(piso_data[0]), 0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        n_done = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_done[0]) n_done++;
        end
        chk(n_done == 0, "midrst_no_done", n_done, 0);
        send(0, 8'h5A, 12'b00_0_01011010_1, 10);
        drain("post_rst_drain");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
